// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - note table, tolerance, lock threshold, encodings and window classifier
package tone_pkg;

    localparam int TOL_SHIFT    = 5;
    localparam int LOCK_MATCHES = 4;

    typedef enum logic [2:0] {
        NOTE_NONE = 3'd0,
        NOTE_DO   = 3'd1,
        NOTE_RE   = 3'd2,
        NOTE_MI   = 3'd3,
        NOTE_FA   = 3'd4,
        NOTE_SO   = 3'd5,
        NOTE_LA   = 3'd6,
        NOTE_XI   = 3'd7
    } note_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRST   = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    // Nominal half-periods in clk cycles, indexed by note_id.
    localparam logic [7:1][15:0] NOMINAL = {
        16'd25310, 16'd28411, 16'd31889, 16'd35792,
        16'd37920, 16'd42569, 16'd47775
    };

    // Seven parallel window compares; the mi and fa windows touch, so the lower note_id wins.
    function automatic logic [2:0] classify(input logic [15:0] h, input int scale);
        logic [2:0]  cls;
        logic [15:0] nom;
        logic [15:0] tol;
        cls = 3'd0;
        for (int k = 7; k >= 1; k--) begin
            nom = NOMINAL[k] >> scale;
            tol = nom >> TOL_SHIFT;
            if ((h >= nom - tol) && (h <= nom + tol)) begin
                cls = 3'(k);
            end
        end
        return cls;
    endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// rtl/tone_edge_sync.sv - two-flop synchronizer with either-polarity edge detect
module tone_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic edge_det
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign dout     = s2;
    assign edge_det = s2 ^ prev;

endmodule

// File: rtl/tone_decoder.sv
// rtl/tone_decoder.sv - measures tone_in half-period and locks onto one of seven notes
module tone_decoder
    import tone_pkg::*;
#(
    parameter int          SCALE   = 0,
    parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tone_in,
    output logic [2:0]  note_id,
    output logic        note_valid,
    output logic        note_change,
    output logic [15:0] half_period
);

    logic        sync_unused;
    logic        edge_det;
    logic [15:0] cnt;
    logic        sat;
    logic [2:0]  cls;

    state_e      state;
    state_e      state_n;
    logic [2:0]  cand;
    logic [2:0]  cand_n;
    logic [2:0]  match;
    logic [2:0]  match_n;
    logic [2:0]  note_n;

    tone_edge_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .din      (tone_in),
        .dout     (sync_unused),
        .edge_det (edge_det)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= 16'd0;
            half_period <= 16'd0;
        end else if (edge_det) begin
            cnt         <= 16'd1;
            half_period <= cnt;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign sat = (cnt == CNT_MAX);
    assign cls = classify(cnt, SCALE);

    always_comb begin
        state_n = state;
        cand_n  = cand;
        match_n = match;
        note_n  = note_id;
        if (edge_det) begin
            unique case (state)
                ST_IDLE: begin
                    state_n = ST_FIRST;
                end
                ST_FIRST, ST_ACQUIRE: begin
                    state_n = ST_ACQUIRE;
                    if ((cls != NOTE_NONE) && (cls == cand)) begin
                        match_n = match + 3'd1;
                    end else begin
                        cand_n  = cls;
                        match_n = {2'b00, cls != NOTE_NONE};
                    end
                    if (match_n == 3'(LOCK_MATCHES)) begin
                        state_n = ST_LOCKED;
                        note_n  = cand_n;
                    end
                end
                ST_LOCKED: begin
                    if (cls != cand) begin
                        state_n = ST_ACQUIRE;
                        note_n  = NOTE_NONE;
                        cand_n  = cls;
                        match_n = {2'b00, cls != NOTE_NONE};
                    end
                end
            endcase
        end else if (sat) begin
            // An edge in the saturation cycle takes the branch above instead.
            state_n = ST_IDLE;
            note_n  = NOTE_NONE;
            cand_n  = 3'd0;
            match_n = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cand        <= 3'd0;
            match       <= 3'd0;
            note_id     <= 3'd0;
            note_valid  <= 1'b0;
            note_change <= 1'b0;
        end else begin
            state       <= state_n;
            cand        <= cand_n;
            match       <= match_n;
            note_id     <= note_n;
            note_valid  <= (state_n == ST_LOCKED);
            note_change <= (note_n != note_id);
        end
    end

endmodule

// File: tb/tb_tone_decoder.sv
// tb/tb_tone_decoder.sv - randomized self-checking bench for tone_decoder with a streak-based reference model
module tb_tone_decoder;

    localparam int          SCALE   = 6;
    localparam int          CMAX    = 2047;
    localparam logic [15:0] CNT_MAX = 16'd2047;

    logic        clk = 1'b0;
    logic        rst;
    logic        tone_in;
    logic [2:0]  note_id;
    logic        note_valid;
    logic        note_change;
    logic [15:0] half_period;

    always #5 clk = ~clk;

    tone_decoder #(.SCALE(SCALE), .CNT_MAX(CNT_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .tone_in     (tone_in),
        .note_id     (note_id),
        .note_valid  (note_valid),
        .note_change (note_change),
        .half_period (half_period)
    );

    int cyc = 0;
    int chg_seen = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (note_change === 1'b1) chg_seen <= chg_seen + 1;

    int n_cmp = 0;
    int n_bad = 0;

    int nom_full [7] = '{47775, 42569, 37920, 35792, 31889, 28411, 25310};

    bit armed = 1'b0;
    int streak = 0;
    int streak_cls = 0;
    int exp_note = 0;
    int exp_chg = 0;
    int last_cyc = 0;

    function automatic int nom(input int k);
        return nom_full[k-1] / (1 << SCALE);
    endfunction

    function automatic int ref_class(input int h);
        int n;
        int d;
        for (int k = 1; k <= 7; k++) begin
            n = nom(k);
            d = (h > n) ? h - n : n - h;
            if (d <= n / 32) return k;
        end
        return 0;
    endfunction

    function automatic int jit(input int k);
        int t;
        t = (nom(k) / 32) / 2;
        return int'($urandom_range(2 * t)) - t;
    endfunction

    task automatic model_timeout(input int gap);
        if (armed && gap > CMAX) begin
            armed = 1'b0;
            streak = 0;
            streak_cls = 0;
            if (exp_note != 0) exp_chg++;
            exp_note = 0;
        end
    endtask

    // Toggle tone_in h cycles after the previous toggle, advance the model, wait for outputs.
    task automatic step(input int h);
        int gap;
        int c;
        int nn;
        while (cyc - last_cyc < h) begin @(posedge clk); #1; end
        tone_in = ~tone_in;
        gap = cyc - last_cyc;
        last_cyc = cyc;
        model_timeout(gap);
        if (!armed) begin
            armed = 1'b1;
        end else begin
            c = ref_class(gap);
            if (c != 0 && c == streak_cls) streak++;
            else begin
                streak_cls = c;
                streak = (c != 0) ? 1 : 0;
            end
        end
        nn = (streak >= 4) ? streak_cls : 0;
        if (nn != exp_note) exp_chg++;
        exp_note = nn;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic hold(input int g);
        while (cyc - last_cyc < g) begin @(posedge clk); #1; end
        model_timeout(cyc - last_cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tone_in = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if (note_id !== 3'd0) begin n_bad++; $display("FAIL reset note_id: got %0d want 0", note_id); end
        n_cmp++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL reset note_valid: got %0b want 0", note_valid); end
        n_cmp++; if (note_change !== 1'b0) begin n_bad++; $display("FAIL reset note_change: got %0b want 0", note_change); end
        n_cmp++; if (half_period !== 16'd0) begin n_bad++; $display("FAIL reset half_period: got %0d want 0", half_period); end
        rst = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic test_lock_do();
        for (int i = 0; i < 5; i++) begin
            step(nom(1) + jit(1));
            n_cmp++; if (note_id !== 3'(exp_note)) begin n_bad++; $display("FAIL lock_do note_id edge %0d: got %0d want %0d", i, note_id, exp_note); end
            n_cmp++; if (note_valid !== (exp_note != 0)) begin n_bad++; $display("FAIL lock_do note_valid edge %0d: got %0b want %0b", i, note_valid, exp_note != 0); end
        end
        n_cmp++; if (note_id !== 3'd1) begin n_bad++; $display("FAIL lock_do final note_id: got %0d want 1", note_id); end
        n_cmp++; if (chg_seen != exp_chg) begin n_bad++; $display("FAIL lock_do note_change pulses: got %0d want %0d", chg_seen, exp_chg); end
    endtask

    task automatic test_between();
        for (int i = 0; i < 6; i++) begin
            step(40000 / (1 << SCALE));
            n_cmp++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL between note_valid edge %0d: got %0b want 0", i, note_valid); end
        end
        n_cmp++; if (half_period !== 16'(40000 / (1 << SCALE))) begin n_bad++; $display("FAIL between half_period: got %0d want %0d", half_period, 40000 / (1 << SCALE)); end
    endtask

    task automatic test_boundary();
        int edge_h;
        edge_h = nom(3) + nom(3) / 32;
        for (int i = 0; i < 5; i++) begin
            step(edge_h);
            n_cmp++; if (note_id !== 3'(exp_note)) begin n_bad++; $display("FAIL boundary_in note_id edge %0d: got %0d want %0d", i, note_id, exp_note); end
        end
        n_cmp++; if (note_id !== 3'd3) begin n_bad++; $display("FAIL boundary_in final note_id: got %0d want 3", note_id); end
        for (int i = 0; i < 6; i++) begin
            step(edge_h + 1);
            n_cmp++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL boundary_out note_valid edge %0d: got %0b want 0", i, note_valid); end
        end
        n_cmp++; if (half_period !== 16'(edge_h + 1)) begin n_bad++; $display("FAIL boundary_out half_period: got %0d want %0d", half_period, edge_h + 1); end
    endtask

    task automatic test_sweep();
        int k;
        for (int s = 0; s < 8; s++) begin
            k = (s % 7) + 1;
            for (int i = 0; i < 5; i++) begin
                step(nom(k) + jit(k));
                n_cmp++; if (note_id !== 3'(exp_note)) begin n_bad++; $display("FAIL sweep note_id note %0d edge %0d: got %0d want %0d", k, i, note_id, exp_note); end
                n_cmp++; if (note_valid !== (exp_note != 0)) begin n_bad++; $display("FAIL sweep note_valid note %0d edge %0d: got %0b want %0b", k, i, note_valid, exp_note != 0); end
            end
        end
        n_cmp++; if (note_id !== 3'd1) begin n_bad++; $display("FAIL sweep final note_id: got %0d want 1", note_id); end
        n_cmp++; if (chg_seen != exp_chg) begin n_bad++; $display("FAIL sweep note_change pulses: got %0d want %0d", chg_seen, exp_chg); end
    endtask

    task automatic test_sat_edge();
        step(CMAX);
        n_cmp++; if (note_id !== 3'(exp_note)) begin n_bad++; $display("FAIL sat_edge note_id: got %0d want %0d", note_id, exp_note); end
        n_cmp++; if (half_period !== CNT_MAX) begin n_bad++; $display("FAIL sat_edge half_period: got %0d want %0d", half_period, CMAX); end
        for (int i = 0; i < 4; i++) begin
            step(nom(1) + jit(1));
            n_cmp++; if (note_id !== 3'(exp_note)) begin n_bad++; $display("FAIL sat_edge relock note_id edge %0d: got %0d want %0d", i, note_id, exp_note); end
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 5; i++) step(nom(6) + jit(6));
        n_cmp++; if (note_id !== 3'd6) begin n_bad++; $display("FAIL timeout locked note_id: got %0d want 6", note_id); end
        hold(CMAX - 4);
        n_cmp++; if (note_id !== 3'(exp_note)) begin n_bad++; $display("FAIL timeout early note_id: got %0d want %0d", note_id, exp_note); end
        hold(CMAX + 8);
        n_cmp++; if (note_id !== 3'(exp_note)) begin n_bad++; $display("FAIL timeout note_id: got %0d want %0d", note_id, exp_note); end
        n_cmp++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL timeout note_valid: got %0b want 0", note_valid); end
        n_cmp++; if (chg_seen != exp_chg) begin n_bad++; $display("FAIL timeout note_change pulses: got %0d want %0d", chg_seen, exp_chg); end
        step(0);
        n_cmp++; if (half_period !== CNT_MAX) begin n_bad++; $display("FAIL timeout saturated half_period: got %0d want %0d", half_period, CMAX); end
    endtask

    task automatic test_reset_relock();
        for (int i = 0; i < 5; i++) step(nom(5) + jit(5));
        n_cmp++; if (note_id !== 3'd5) begin n_bad++; $display("FAIL relock pre note_id: got %0d want 5", note_id); end
        rst = 1'b1;
        tone_in = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({note_id, note_valid, note_change} !== 5'd0 || half_period !== 16'd0) begin
            n_bad++; $display("FAIL relock reset outputs: got id=%0d v=%0b c=%0b hp=%0d want all 0", note_id, note_valid, note_change, half_period);
        end
        rst = 1'b0;
        armed = 1'b0; streak = 0; streak_cls = 0; exp_note = 0;
        last_cyc = cyc;
        for (int i = 0; i < 5; i++) begin
            step(nom(5) + jit(5));
            n_cmp++; if (note_id !== 3'(exp_note)) begin n_bad++; $display("FAIL relock note_id edge %0d: got %0d want %0d", i, note_id, exp_note); end
        end
        n_cmp++; if (note_id !== 3'd5) begin n_bad++; $display("FAIL relock final note_id: got %0d want 5", note_id); end
        n_cmp++; if (chg_seen != exp_chg) begin n_bad++; $display("FAIL relock note_change pulses: got %0d want %0d", chg_seen, exp_chg); end
    endtask

    initial begin
        test_reset();
        test_lock_do();
        test_between();
        test_boundary();
        test_sweep();
        test_sat_edge();
        test_timeout();
        test_reset_relock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
